// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the fetch (read-only) and data sides.
// Data has priority; a starvation counter forces fetch through after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              OWNER
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_starve;

  logic w_dreq;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_i_owned;
  logic w_resp;

  assign w_dreq    = D_READ | D_WRITE;
  assign w_idle    = (r_state == S_IDLE);
  assign w_resp    = (r_state == S_RESP);
  assign w_grant_i = w_idle & I_READ & ((r_starve == LIMIT) | ~w_dreq);
  assign w_grant_d = w_idle & w_dreq & ~w_grant_i;
  // While fetch holds the port it is not losing cycles.
  assign w_i_owned = ~w_idle & ~OWNER;

  assign I_BUSYWAIT = I_READ & ~(w_resp & ~OWNER);
  assign D_BUSYWAIT = w_dreq & ~(w_resp & OWNER);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_starve      <= '0;
      OWNER         <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
    end else begin
      if (~I_READ | w_grant_i | w_i_owned) begin
        r_starve <= '0;
      end else if (r_starve != LIMIT) begin
        r_starve <= r_starve + CNT_W'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            OWNER       <= 1'b0;
            MEM_ADDRESS <= I_ADDRESS;
            MEM_READ    <= 1'b1;
            MEM_WRITE   <= 1'b0;
            r_state     <= S_ISSUE;
          end else if (w_grant_d) begin
            OWNER         <= 1'b1;
            MEM_ADDRESS   <= D_ADDRESS;
            MEM_WRITEDATA <= D_WRITEDATA;
            MEM_WRITE     <= D_WRITE;
            MEM_READ      <= ~D_WRITE;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (~MEM_BUSYWAIT) begin
            if (MEM_READ) begin
              if (OWNER) begin
                D_READDATA <= MEM_READDATA;
              end else begin
                I_READDATA <= MEM_READDATA;
              end
            end
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small busy-cycle memory model.
// Expected responses are queued by the stimulus; a monitor pops them.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [31:0] D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic        OWNER;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_READ       (I_READ),
    .I_ADDRESS    (I_ADDRESS),
    .I_READDATA   (I_READDATA),
    .I_BUSYWAIT   (I_BUSYWAIT),
    .D_READ       (D_READ),
    .D_WRITE      (D_WRITE),
    .D_ADDRESS    (D_ADDRESS),
    .D_WRITEDATA  (D_WRITEDATA),
    .D_READDATA   (D_READDATA),
    .D_BUSYWAIT   (D_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .OWNER        (OWNER)
  );

  typedef struct {
    logic        side;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] mem [0:255];
  int          busy_n = 0;
  int          scyc = 0;
  int          rd_run = 0;
  int          last_rd_len = 0;
  int          rd_total = 0;
  int          wr_total = 0;

  assign MEM_READDATA = mem[MEM_ADDRESS[9:2]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic side, input logic [31:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic side, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_resp: side %0d data %h, queue empty",
               side, data);
    end else begin
      e = sb.pop_front();
      chk("resp_side", 32'(side), 32'(e.side));
      chk("resp_owner", 32'(OWNER), 32'(e.side));
      chk("resp_data", data, e.data);
    end
  endtask

  // Memory: ISSUE cycle plus busy_n busy WAIT cycles, then ready.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h00A00093;
    mem[8'h41] = 32'h11111111;
    mem[8'h60] = 32'h22222222;
    mem[8'h44] = 32'h44444444;
    mem[8'h42] = 32'h66666666;
    mem[8'hC0] = 32'h33333333;
    mem[8'h43] = 32'h55555555;
    MEM_BUSYWAIT = 1'b0;
    forever begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) begin
        scyc++;
        MEM_BUSYWAIT = (scyc <= busy_n + 1);
        if (MEM_WRITE && !MEM_BUSYWAIT)
          mem[MEM_ADDRESS[9:2]] = MEM_WRITEDATA;
      end else begin
        scyc = 0;
        MEM_BUSYWAIT = 1'b0;
      end
      if (MEM_WRITE) wr_total++;
      if (MEM_READ) begin
        rd_run++;
        rd_total++;
      end else if (rd_run != 0) begin
        last_rd_len = rd_run;
        rd_run = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (I_READ && !I_BUSYWAIT) pop_chk(1'b0, I_READDATA);
      if ((D_READ || D_WRITE) && !D_BUSYWAIT) pop_chk(1'b1, D_READDATA);
    end
  end

  task automatic do_i(input logic [31:0] a, output int lat);
    I_ADDRESS = a;
    I_READ = 1'b1;
    lat = 0;
    forever begin
      @(negedge CLK);
      lat++;
      if (!I_BUSYWAIT) break;
      if (lat > 100) begin
        n_checks++;
        n_err++;
        $display("FAIL i_timeout: busywait still %0d, required 0", I_BUSYWAIT);
        break;
      end
    end
    @(posedge CLK);
    #1;
    I_READ = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a, input logic rd, input logic wr,
                      input logic [31:0] wd);
    int n;
    D_ADDRESS = a;
    D_WRITEDATA = wd;
    D_READ = rd;
    D_WRITE = wr;
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if (!D_BUSYWAIT) break;
      if (n > 100) begin
        n_checks++;
        n_err++;
        $display("FAIL d_timeout: busywait still %0d, required 0", D_BUSYWAIT);
        break;
      end
    end
    @(posedge CLK);
    #1;
    D_READ = 1'b0;
    D_WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int lat2;
    int rd0;
    int wr0;
    int bad;
    RESET = 1'b1;
    I_READ = 1'b0;
    I_ADDRESS = '0;
    D_READ = 1'b0;
    D_WRITE = 1'b0;
    D_ADDRESS = '0;
    D_WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_mem_read", 32'(MEM_READ), 0);
    chk("rst_mem_write", 32'(MEM_WRITE), 0);
    chk("rst_mem_addr", MEM_ADDRESS, 0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 0);
    chk("rst_i_rdata", I_READDATA, 0);
    chk("rst_d_rdata", D_READDATA, 0);
    chk("rst_owner", 32'(OWNER), 0);
    @(posedge CLK);
    #1;

    // 1: single fetch, 3 busy cycles
    busy_n = 3;
    push(1'b0, 32'h00A00093);
    do_i(32'h100, lat);
    chk("t1_latency", 32'(lat), 7);
    chk("t1_read_len", 32'(last_rd_len), 5);

    // 2: simultaneous fetch and load, data first
    busy_n = 1;
    push(1'b1, 32'h22222222);
    push(1'b0, 32'h11111111);
    fork
      do_i(32'h104, lat);
      do_d(32'h180, 1'b1, 1'b0, 32'h0);
    join

    // 3: back-to-back stores starve fetch until counter saturates
    busy_n = 0;
    push(1'b1, 32'h22222222);
    push(1'b0, 32'h44444444);
    push(1'b1, 32'h22222222);
    push(1'b1, 32'h22222222);
    fork
      do_i(32'h110, lat);
      begin
        do_d(32'h1C0, 1'b0, 1'b1, 32'hA0A0A0A0);
        do_d(32'h1C4, 1'b0, 1'b1, 32'hB1B1B1B1);
        do_d(32'h1C8, 1'b0, 1'b1, 32'hC2C2C2C2);
      end
    join
    chk("t3_mem0", mem[8'h70], 32'hA0A0A0A0);
    chk("t3_mem2", mem[8'h72], 32'hC2C2C2C2);

    // 4: read+write together is a write
    busy_n = 1;
    rd0 = rd_total;
    wr0 = wr_total;
    push(1'b1, 32'h22222222);
    do_d(32'h200, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("t4_mem", mem[8'h80], 32'hDEADBEEF);
    chk("t4_no_read", 32'(rd_total - rd0), 0);
    chk("t4_write_len", 32'(wr_total - wr0), 3);

    // 5: reset during WAIT abandons the access
    busy_n = 5;
    I_ADDRESS = 32'h108;
    I_READ = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t5_mid_read", 32'(MEM_READ), 1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    I_READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("t5_mem_read", 32'(MEM_READ), 0);
    chk("t5_mem_write", 32'(MEM_WRITE), 0);
    chk("t5_i_rdata", I_READDATA, 0);
    chk("t5_d_rdata", D_READDATA, 0);
    @(negedge CLK);
    chk("t5_idle_read", 32'(MEM_READ), 0);
    @(posedge CLK);
    #1;

    // 6: load dropped in WAIT still completes; fetch follows
    busy_n = 2;
    D_ADDRESS = 32'h300;
    D_READ = 1'b1;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    D_READ = 1'b0;
    bad = 0;
    push(1'b0, 32'h55555555);
    fork
      do_i(32'h10C, lat2);
      begin
        repeat (12) begin
          @(negedge CLK);
          if (D_BUSYWAIT) bad++;
        end
      end
    join
    chk("t6_d_busy", 32'(bad), 0);
    chk("t6_d_rdata", D_READDATA, 32'h33333333);
    chk("t6_i_rdata", I_READDATA, 32'h55555555);

    repeat (3) @(posedge CLK);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
